sa9_group_rr_arbiter: RTL and testbench
=======================================

// Module: sa9_group_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one common resource (bus/port) among the NUM_REQ
//  sibling sa9 child instances of a group node. It grants exclusive ownership,
//  tracks hold time, forces release on overrun and rotates priority fairly.
//  Sits beside the child instances inside the group module.
// PARAMETERS
//  NUM_REQ   5   number of requesters (>=2)
//  MAX_HOLD  16  max cycles one grant may be held before forced release (>=2)
//  IDW       $clog2(NUM_REQ)  width of grant_id (derived, do not override)
// PORTS
//  clk          in   1        clock, rising edge
//  rst_n        in   1        asynchronous active-low reset
//  req          in   NUM_REQ  request per requester, level, held until granted
//  release      in   NUM_REQ  owner pulses its bit to end its grant
//  grant        out  NUM_REQ  one-hot grant (all zero when idle)
//  grant_valid  out  1        |grant
//  grant_id     out  IDW      index of current owner (0 when idle)
//  timeout      out  1        1-cycle pulse: grant forcibly ended at MAX_HOLD
//  busy         out  1        high in BUSY or GAP state
// BEHAVIOUR
//  - Reset (async assert, sync deassert by system): state=IDLE, grant=0,
//    grant_valid=0, grant_id=0, timeout=0, busy=0, rr_ptr=0, hold_cnt=0.
//    Reset mid-grant drops grant immediately; no timeout pulse.
//  - All outputs registered. States: IDLE, BUSY, GAP.
//  - IDLE: if req!=0, winner = first set bit scanning rr_ptr, rr_ptr+1, ...
//    mod NUM_REQ; next cycle grant[winner]=1, grant_id=winner, state=BUSY,
//    hold_cnt=0. req at edge t -> grant visible after edge t+1 (latency 1).
//  - BUSY: hold_cnt increments each cycle. Grant ends when any of:
//    (a) release[grant_id]=1; (b) req[grant_id]=0 (abort, same as release);
//    (c) hold_cnt==MAX_HOLD-1 -> timeout=1 for the next cycle.
//    (a)/(b) coincident with (c): normal release wins, timeout stays 0.
//    release bits of non-owners are ignored.
//    On end: grant=0, rr_ptr=(grant_id+1) mod NUM_REQ (wrap NUM_REQ-1 -> 0),
//    state=GAP. Owner holds grant for exactly MAX_HOLD cycles max.
//  - GAP: one dead cycle, grant=0, busy=1; then IDLE. Guarantees >=1 idle cycle
//    between owners; back-to-back grants are 2 cycles apart minimum.
//  - A requester whose req rises during BUSY/GAP waits; no request is lost.
//  - Only one grant bit ever set; grant_id always consistent with grant.
// TESTING
//  1 Reset: rst_n=0 mid-BUSY -> grant=0, rr_ptr=0 same cycle; after release
//    req=5'b00100 -> grant=5'b00100, grant_id=2 one cycle later.
//  2 Fairness: req=5'b11111 held, each owner releases after 3 cycles -> grant
//    order 0,1,2,3,4,0 with one GAP cycle between each.
//  3 Timeout: req=5'b00010 held, no release, MAX_HOLD=16 -> grant high exactly
//    16 cycles, timeout pulse 1 cycle, then GAP, then regrant id 1.
//  4 Collision: release[owner] in same cycle hold_cnt==15 -> timeout stays 0.
//  5 Abort/wrap: owner 4 drops req at cycle 2 -> grant ends, rr_ptr=0; with
//    req=5'b10001 next grant id 0. Non-owner release pulses have no effect.
//  6 Assertions: $onehot0(grant), grant_valid==|grant, timeout never 2 cycles.

Source files
------------

// File: rtl/sa9_group_rr_arbiter_if.sv
// Request/grant bundle between the sa9 siblings (master) and their group arbiter (slave).
// `release` is a reserved word, so the owner's release pulses travel on rls.
interface sa9_group_rr_arbiter_if #(
    parameter int NUM_REQ = 5
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] rls;
    logic [NUM_REQ-1:0] grant;
    logic               grant_valid;
    logic [IDW-1:0]     grant_id;
    logic               timeout;
    logic               busy;

    modport master (
        output req, rls,
        input  grant, grant_valid, grant_id, timeout, busy
    );

    modport slave (
        input  req, rls,
        output grant, grant_valid, grant_id, timeout, busy
    );
endinterface

// File: rtl/sa9_group_rr_arbiter.sv
// Round-robin owner arbiter for the shared resource of an sa9 group node:
// exclusive one-hot grant, hold-time limit with timeout pulse, one dead GAP cycle between owners.
module sa9_group_rr_arbiter #(
    parameter int NUM_REQ  = 5,
    parameter int MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sa9_group_rr_arbiter_if.slave bus
);
    localparam int          IDW = $clog2(NUM_REQ);
    localparam int          HCW = $clog2(MAX_HOLD);
    localparam int unsigned N   = NUM_REQ;

    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

    state_t             state, state_n;
    logic [NUM_REQ-1:0] grant_q, grant_n;
    logic               grant_valid_q, grant_valid_n;
    logic [IDW-1:0]     id_q, id_n;
    logic [IDW-1:0]     rr_ptr, rr_ptr_n;
    logic [HCW-1:0]     hold_cnt, hold_cnt_n;
    logic               timeout_q, timeout_n;
    logic               busy_q, busy_n;
    logic [IDW-1:0]     pick;
    logic               found;
    logic               owner_done;
    logic               hold_expired;

    function automatic logic [IDW-1:0] wrap_inc(input int unsigned base, input int unsigned off);
        int unsigned s;
        s = base + off;
        if (s >= N) s = s - N;
        return IDW'(s);
    endfunction

    // First requester at or after rr_ptr, wrapping round the ring.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && bus.req[wrap_inc(32'(rr_ptr), i)]) begin
                found = 1'b1;
                pick  = wrap_inc(32'(rr_ptr), i);
            end
        end
    end

    always_comb begin
        owner_done   = bus.rls[id_q] || !bus.req[id_q];
        hold_expired = (hold_cnt == HCW'(MAX_HOLD - 1));
    end

    always_comb begin
        state_n    = state;
        grant_n    = grant_q;
        id_n       = id_q;
        rr_ptr_n   = rr_ptr;
        hold_cnt_n = hold_cnt;
        timeout_n  = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n       = BUSY;
                    grant_n       = '0;
                    grant_n[pick] = 1'b1;
                    id_n          = pick;
                    hold_cnt_n    = '0;
                end
            end
            BUSY: begin
                if (owner_done || hold_expired) begin
                    // a voluntary release in the last allowed cycle is not a timeout
                    timeout_n = !owner_done;
                    state_n   = GAP;
                    grant_n   = '0;
                    id_n      = '0;
                    rr_ptr_n  = wrap_inc(32'(id_q), 1);
                end else begin
                    hold_cnt_n = hold_cnt + HCW'(1);
                end
            end
            GAP:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
        grant_valid_n = |grant_n;
        busy_n        = (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            id_q          <= '0;
            rr_ptr        <= '0;
            hold_cnt      <= '0;
            timeout_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state         <= state_n;
            grant_q       <= grant_n;
            grant_valid_q <= grant_valid_n;
            id_q          <= id_n;
            rr_ptr        <= rr_ptr_n;
            hold_cnt      <= hold_cnt_n;
            timeout_q     <= timeout_n;
            busy_q        <= busy_n;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.grant_id    = id_q;
    assign bus.timeout     = timeout_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_sa9_group_rr_arbiter.sv
// Scoreboard bench: the stimulus thread predicts each cycle's outputs with an owner/pointer model,
// a negedge monitor pops and compares them and checks the one-hot / single-pulse invariants.
module tb_sa9_group_rr_arbiter;
    localparam int N   = 5;
    localparam int MH  = 16;
    localparam int IDW = $clog2(N);

    typedef struct {
        int unsigned    cyc;
        logic [N-1:0]   grant;
        logic [IDW-1:0] id;
        logic           tmo;
        logic           busy;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sa9_group_rr_arbiter_if #(.NUM_REQ(N)) bus ();
    sa9_group_rr_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          checks  = 0;
    int          errors  = 0;
    int unsigned cyc     = 0;
    bit          chk_en  = 0;
    exp_t        q[$];
    int          starts[$];
    int          glens[$];
    int          tmo_cnt = 0;
    int          run_len = 0;
    logic        prev_gv  = 1'b0;
    logic        prev_tmo = 1'b0;

    // Model: who owns the resource, for how many cycles so far, where the scan starts next.
    int m_owner = -1;
    int m_held  = 0;
    int m_ptr   = 0;
    bit m_gap   = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (chk_en && rst_n) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                check("stale_expectation", e.cyc, cyc);
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                check("outputs{grant,gv,id,tmo,busy}",
                      32'({bus.grant, bus.grant_valid, bus.grant_id, bus.timeout, bus.busy}),
                      32'({e.grant, |e.grant, e.id, e.tmo, e.busy}));
            end
            check("onehot0_grant", 32'($onehot0(bus.grant)), 1);
            check("grant_valid_is_or", 32'(bus.grant_valid), 32'(|bus.grant));
            check("id_consistent", 32'(bus.grant_valid ? bus.grant[bus.grant_id] : (bus.grant_id == '0)), 1);
            check("timeout_single_cycle", 32'(prev_tmo & bus.timeout), 0);
            if (bus.grant_valid && !prev_gv) begin
                starts.push_back(int'(bus.grant_id));
                run_len = 0;
            end
            if (bus.grant_valid) run_len++;
            if (!bus.grant_valid && prev_gv) glens.push_back(run_len);
            if (bus.timeout) tmo_cnt++;
            prev_gv  = bus.grant_valid;
            prev_tmo = bus.timeout;
        end
    end

    // Drive one cycle of inputs, advance the model, queue the outputs expected after the edge.
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] l);
        exp_t e;
        bit   t;
        t       = 0;
        bus.req = r;
        bus.rls = l;
        if (m_owner >= 0) begin
            if (l[m_owner] || !r[m_owner]) begin
                m_ptr = (m_owner + 1) % N; m_owner = -1; m_gap = 1;
            end else if (m_held == MH) begin
                t = 1;
                m_ptr = (m_owner + 1) % N; m_owner = -1; m_gap = 1;
            end else begin
                m_held++;
            end
        end else if (m_gap) begin
            m_gap = 0;
        end else begin
            for (int k = 0; k < N; k++)
                if (m_owner < 0 && r[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    m_held  = 1;
                end
        end
        e.cyc   = cyc + 1;
        e.grant = '0;
        e.id    = '0;
        if (m_owner >= 0) begin
            e.grant[m_owner] = 1'b1;
            e.id             = IDW'(m_owner);
        end
        e.tmo  = t;
        e.busy = (m_owner >= 0) || m_gap;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_out();
        repeat (4) step('0, '0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_grant"},       32'(bus.grant), 0);
        check({tag, "_grant_valid"}, 32'(bus.grant_valid), 0);
        check({tag, "_grant_id"},    32'(bus.grant_id), 0);
        check({tag, "_timeout"},     32'(bus.timeout), 0);
        check({tag, "_busy"},        32'(bus.busy), 0);
    endtask

    task automatic do_reset();
        chk_en  = 0;
        q.delete();
        bus.req = '0;
        bus.rls = '0;
        rst_n   = 1'b0;
        #1;
        check_idle("reset_async");
        @(negedge clk);
        rst_n    = 1'b1;
        m_owner  = -1; m_held = 0; m_ptr = 0; m_gap = 0;
        prev_gv  = 1'b0;
        prev_tmo = 1'b0;
        run_len  = 0;
        @(posedge clk);
        #1;
        chk_en = 1;
    endtask

    initial begin
        logic [N-1:0] r, l;
        int base, gbase, tbase, k;

        bus.req = '0;
        bus.rls = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1;

        // Fairness: everyone requests, each owner releases in its third cycle.
        base = starts.size(); gbase = glens.size();
        for (int c = 0; c < 100 && starts.size() < base + 6; c++)
            step('1, (m_owner >= 0 && m_held == 3) ? oh(m_owner) : '0);
        idle_out();
        check("fair_grant_count", 32'(starts.size() - base), 6);
        for (int i = 0; i < 6; i++)
            if (base + i < starts.size()) check("fair_order", 32'(starts[base + i]), 32'(i % N));
        for (int i = 0; i < 5; i++)
            if (gbase + i < glens.size()) check("fair_hold_len", 32'(glens[gbase + i]), 3);

        // Timeout: requester 1 never releases.
        base = starts.size(); gbase = glens.size(); tbase = tmo_cnt;
        for (int c = 0; c < 60 && starts.size() < base + 2; c++) step(5'b00010, '0);
        idle_out();
        check("timeout_pulses", 32'(tmo_cnt - tbase), 1);
        if (gbase < glens.size())     check("timeout_hold_len", 32'(glens[gbase]), MH);
        if (base + 1 < starts.size()) check("timeout_regrant_id", 32'(starts[base + 1]), 1);
        else                          check("timeout_regrant_seen", 32'(starts.size() - base), 2);

        // Collision: release in the last allowed cycle suppresses the timeout.
        gbase = glens.size(); tbase = tmo_cnt;
        for (int c = 0; c < 40 && glens.size() < gbase + 1; c++)
            step(5'b00010, (m_owner == 1 && m_held == MH) ? 5'b00010 : 5'b00000);
        idle_out();
        check("collision_no_timeout", 32'(tmo_cnt - tbase), 0);
        if (gbase < glens.size()) check("collision_hold_len", 32'(glens[gbase]), MH);

        // Reset mid-grant with rr_ptr parked on 4: afterwards the scan must restart at 0.
        for (int c = 0; c < 10 && m_owner != 3; c++) step(5'b01000, '0);
        step(5'b00000, 5'b01000);
        for (int c = 0; c < 10 && !(m_owner == 3 && m_held >= 3); c++) step(5'b01000, '0);
        do_reset();
        base = starts.size();
        for (int c = 0; c < 10 && m_owner < 0; c++) step(5'b10100, '0);
        idle_out();
        if (base < starts.size()) check("post_reset_grant_id", 32'(starts[base]), 2);
        else                      check("post_reset_grant_seen", 32'(starts.size() - base), 1);

        // Abort by owner 4 with non-owner release noise, then wrap to 0.
        base = starts.size(); gbase = glens.size();
        for (int c = 0; c < 10 && m_owner != 4; c++) step(5'b10000, '0);
        for (int c = 0; c < 10 && m_owner == 4; c++) step((m_held == 2) ? 5'b00000 : 5'b10000, 5'b00011);
        for (int c = 0; c < 10 && m_owner < 0; c++) step(5'b10001, '0);
        idle_out();
        if (gbase < glens.size())     check("abort_hold_len", 32'(glens[gbase]), 2);
        if (base + 1 < starts.size()) check("wrap_next_id", 32'(starts[base + 1]), 0);
        else                          check("wrap_grants_seen", 32'(starts.size() - base), 2);

        // Random traffic: requests stay up until served, owners release/abort at random.
        r = '0;
        for (int c = 0; c < 2400; c++) begin
            if (c == 1200) begin
                do_reset();
                r = '0;
            end
            l = '0;
            for (int i = 0; i < N; i++)
                if (i != m_owner && !r[i] && $urandom_range(0, 5) == 0) r[i] = 1'b1;
            if (m_owner >= 0) begin
                case ($urandom_range(0, 15))
                    0: begin l[m_owner] = 1'b1; r[m_owner] = 1'($urandom_range(0, 1)); end
                    1: r[m_owner] = 1'b0;
                    default: ;
                endcase
            end
            k = int'($urandom_range(0, N - 1));
            if (k != m_owner && $urandom_range(0, 3) == 0) l[k] = 1'b1;
            step(r, l);
        end
        idle_out();
        @(negedge clk);
        #1;
        check("queue_drained", 32'(q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
